keccak_scan_ctrl: RTL
=====================

// Module: keccak_scan_ctrl
// PURPOSE
//   Nonce-scan controller wrapped around the fully pipelined keccak256_80 core. Accepts one job
//   (76-byte header, target, nonce range). Drives the core one 640-bit input per clock with
//   incrementing nonce, tracks each nonce through the fixed core latency, compares each returned
//   hash against the target and queues winning nonces in a small result FIFO.
// PARAMETERS
//   PIPE_LATENCY  98  clocks from core_data registered out to matching core_hash at input (>=2)
//   FIFO_DEPTH    4   result FIFO entries; power of two, >=2
// PORTS
//   clk               in   1    clock, all logic on rising edge
//   rst_n             in   1    synchronous active-low reset
//   work_valid        in   1    job offered
//   work_ready        out  1    high only in IDLE
//   work_header       in   608  header bytes 0..75, byte 0 in [607:600]
//   work_target       in   256  unsigned big-endian target
//   work_nonce_start  in   32   first nonce
//   work_nonce_end    in   32   last nonce, inclusive
//   abort             in   1    kill current job
//   core_data         out  640  {header, nonce}; nonce in [31:0]
//   core_hash         in   256  core output, big-endian 256-bit value
//   res_valid         out  1    FIFO non-empty
//   res_ready         in   1    pop when res_valid & res_ready
//   res_nonce         out  32   winning nonce at FIFO head
//   busy              out  1    state != IDLE
//   done              out  1    one-cycle pulse on DRAIN->IDLE
//   res_overflow      out  1    sticky: a winner was dropped on full FIFO
// BEHAVIOUR
//   - Reset: state IDLE, work_ready=1, core_data=0, res_valid=0, busy=0, done=0, res_overflow=0,
//     in-flight valid line and FIFO cleared.
//   - FSM IDLE->SCAN on work_valid&work_ready (cycle T): latch header/target/range, cur=start,
//     out_nonce=start, clear res_overflow. FIFO contents are kept.
//   - SCAN: each cycle core_data <= {header,cur}, tag=1 into PIPE_LATENCY-deep valid line,
//     cur <= cur+1 mod 2^32. First issue at T+1. Issuing nonce==end -> DRAIN next cycle.
//   - Range wraps: start=FFFFFFFF,end=00000001 -> 3 nonces; start==end -> exactly 1 nonce.
//   - IDLE/DRAIN: core_data holds last value, tag=0.
//   - DRAIN: stay until valid line all zero, then IDLE with done=1 for that one cycle.
//   - Checking: nonce issued at cycle N has hash at core_hash in cycle N+PIPE_LATENCY. When tag
//     emerges: winner iff core_hash <= target (unsigned 256-bit, equality wins); out_nonce++
//     for every emerging tag. Compare result registered; push at N+PIPE_LATENCY+1, res_valid
//     visible N+PIPE_LATENCY+2.
//   - FIFO: push and pop same cycle when full -> both happen, no drop. Push when full without
//     pop -> drop, res_overflow=1 until next job accept or reset.
//   - abort (any state): valid line cleared, pending compare discarded, state IDLE next cycle,
//     done not pulsed, FIFO kept. abort wins over work accept in same cycle.
//   - Reset mid-job: all state as reset, FIFO emptied, no done.
// CONFIGURATION
//   KECCAK_SCAN_STATS_EN defined: extra outputs stat_hashes[47:0] (count of tags emerged),
//     stat_wins[31:0] (winners pushed), stat_drops[15:0] (saturating); zero on reset only,
//     wrap for 48/32-bit counters.
//   Undefined: ports absent; all other behaviour identical.
// TESTING (bench: core model = PIPE_LATENCY delay line + reference keccak256; also PIPE_LATENCY=4)
//   - start=0,end=9, target=all-ones -> 10 results 0..9 in order, done pulse, busy low after.
//   - start=FFFFFFFE,end=00000001, target=0 -> 4 core issues (FFFFFFFE..1), no results, done.
//   - target=hash(nonce 5) exactly, range 0..9 -> single result 5 (equality wins).
//   - FIFO_DEPTH=4, res_ready=0, target all-ones, 6 nonces -> 4 held, res_overflow=1;
//     6 nonces with simultaneous pop each cycle -> no drop.
//   - abort 3 cycles into 0..99 -> IDLE next cycle, no further results, no done; new job
//     accepted next cycle.
//   - rst_n low mid-DRAIN -> all outputs at reset values next cycle; STATS_EN: counters zero.

Source files
------------

// File: rtl/keccak_scan_ctrl.sv
// Nonce-scan controller around a fully pipelined keccak256_80 core.
// Optional statistics counters: define KECCAK_SCAN_STATS_EN.
module keccak_scan_ctrl #(
  parameter int PIPE_LATENCY = 98,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         work_valid,
  output logic         work_ready,
  input  logic [607:0] work_header,
  input  logic [255:0] work_target,
  input  logic [31:0]  work_nonce_start,
  input  logic [31:0]  work_nonce_end,
  input  logic         abort,
  output logic [639:0] core_data,
  input  logic [255:0] core_hash,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [31:0]  res_nonce,
  output logic         busy,
  output logic         done,
  output logic         res_overflow
`ifdef KECCAK_SCAN_STATS_EN
  ,
  output logic [47:0]  stat_hashes,
  output logic [31:0]  stat_wins,
  output logic [15:0]  stat_drops
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0]   CNT_ONE = 1;
  localparam logic [PW-1:0] PTR_ONE = 1;
  localparam logic [PW:0]   CNT_FULL = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN
  } state_t;

  state_t state, state_nx;
  logic   done_nx;

  logic [607:0] header;
  logic [255:0] target;
  logic [31:0]  cur;
  logic [31:0]  last;
  logic [31:0]  out_nonce;

  logic [PIPE_LATENCY-1:0] vline;

  logic        cmp_valid;
  logic        cmp_win;
  logic [31:0] cmp_nonce;

  logic [31:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;

  logic accept;
  logic issue;
  logic emerge;
  logic push;
  logic pop;
  logic full;
  logic wr_en;
  logic drop;

  assign accept = (state == IDLE) && work_valid && !abort;
  assign issue  = (state == SCAN) && !abort;
  assign emerge = vline[PIPE_LATENCY-1] && !abort;
  assign push   = cmp_valid && cmp_win && !abort;
  assign pop    = res_valid && res_ready;
  assign full   = (count == CNT_FULL);
  assign wr_en  = push && (!full || pop);
  assign drop   = push && full && !pop;

  assign work_ready = (state == IDLE);
  assign busy       = (state != IDLE);
  assign res_valid  = (count != '0);
  assign res_nonce  = mem[rd_ptr];

  // State register and done pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= done_nx;
    end
  end

  // Next state; abort overrides everything and suppresses done
  always_comb begin
    state_nx = state;
    done_nx  = 1'b0;
    if (abort) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (work_valid) state_nx = SCAN;
        end
        SCAN: begin
          if (cur == last) state_nx = DRAIN;
        end
        DRAIN: begin
          if (vline == '0) begin
            state_nx = IDLE;
            done_nx  = 1'b1;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // Job latch, nonce issue and emerging-nonce tracking
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      header    <= '0;
      target    <= '0;
      cur       <= '0;
      last      <= '0;
      out_nonce <= '0;
      core_data <= '0;
    end else if (accept) begin
      header    <= work_header;
      target    <= work_target;
      cur       <= work_nonce_start;
      last      <= work_nonce_end;
      out_nonce <= work_nonce_start;
    end else begin
      if (issue) begin
        core_data <= {header, cur};
        cur       <= cur + 32'd1;
      end
      if (emerge) out_nonce <= out_nonce + 32'd1;
    end
  end

  // Valid line shadowing the core pipeline
  always_ff @(posedge clk) begin
    if (!rst_n || abort) begin
      vline <= '0;
    end else begin
      vline <= {vline[PIPE_LATENCY-2:0], issue};
    end
  end

  // Registered target compare
  always_ff @(posedge clk) begin
    if (!rst_n || abort) begin
      cmp_valid <= 1'b0;
      cmp_win   <= 1'b0;
      cmp_nonce <= '0;
    end else begin
      cmp_valid <= emerge;
      cmp_win   <= (core_hash <= target);
      cmp_nonce <= out_nonce;
    end
  end

  // Result FIFO storage
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= cmp_nonce;
  end

  // Result FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)   rd_ptr <= rd_ptr + PTR_ONE;
      case ({wr_en, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow, cleared when a new job starts
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_overflow <= 1'b0;
    end else if (accept) begin
      res_overflow <= 1'b0;
    end else if (drop) begin
      res_overflow <= 1'b1;
    end
  end

`ifdef KECCAK_SCAN_STATS_EN
  // Statistics; only reset clears them
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_hashes <= '0;
      stat_wins   <= '0;
      stat_drops  <= '0;
    end else begin
      if (emerge) stat_hashes <= stat_hashes + 48'd1;
      if (wr_en)  stat_wins   <= stat_wins + 32'd1;
      if (drop && stat_drops != 16'hFFFF)
        stat_drops <= stat_drops + 16'd1;
    end
  end
`endif

endmodule
